// File: rtl/mpsoc_glip_dii_deframer.sv
// GLIP-to-DII ingress deframer for the MPSoC debug network.
// Turns a stream of {length header, payload words} into DII flits tagged with
// 'last', buffered in a small FIFO. Zero-length and oversize packets are
// swallowed without reaching the debug network.
// Optional packet/drop statistics: define MPSOC_GLIP_DEFRAMER_STATS_EN.
module mpsoc_glip_dii_deframer #(
  parameter int unsigned MAX_PKT_LEN = 12,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] glip_in_data,
  input  logic        glip_in_valid,
  output logic        glip_in_ready,
  output logic [15:0] dii_out_data,
  output logic        dii_out_last,
  output logic        dii_out_valid,
  input  logic        dii_out_ready,
  output logic        busy
`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  state_e        state_q, state_d;
  logic [16:0]   rem_q, rem_d;
  logic [16:0]   hdr_len;

  logic [15:0]   mem_data [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [15:0]   hold_data_q;
  logic          hold_last_q;

  logic fifo_full, fifo_empty;
  logic in_fire, out_fire;
  logic wr_en, wr_last, drop_evt;

  assign fifo_full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Ready depends only on registered state so it never loops through valid/ready.
  assign glip_in_ready = (state_q != StFwd) || !fifo_full;
  assign in_fire       = glip_in_valid && glip_in_ready;

  assign dii_out_valid = !fifo_empty;
  assign out_fire      = dii_out_valid && dii_out_ready;
  // When empty, present the last flit that left so outputs do not wander.
  assign dii_out_data  = fifo_empty ? hold_data_q : mem_data[rd_ptr_q];
  assign dii_out_last  = fifo_empty ? hold_last_q : mem_last[rd_ptr_q];

  assign busy    = (state_q != StIdle) || !fifo_empty;
  assign hdr_len = {1'b0, glip_in_data};

  // Next-state logic: header decode, payload forwarding and discard counting.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wr_en    = 1'b0;
    wr_last  = 1'b0;
    drop_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          if (hdr_len == 17'd0) begin
            drop_evt = 1'b1;
          end else if (hdr_len <= 17'(MAX_PKT_LEN)) begin
            state_d = StFwd;
            rem_d   = hdr_len;
          end else begin
            state_d = StDrop;
            rem_d   = hdr_len;
          end
        end
      end
      StFwd: begin
        if (in_fire) begin
          wr_en   = 1'b1;
          wr_last = (rem_q == 17'd1);
          rem_d   = rem_q - 17'd1;
          if (rem_q == 17'd1) state_d = StIdle;
        end
      end
      StDrop: begin
        if (in_fire) begin
          rem_d = rem_q - 17'd1;
          if (rem_q == 17'd1) begin
            state_d  = StIdle;
            drop_evt = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        rem_d   = '0;
      end
    endcase
  end

  // FSM state and remaining-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // FIFO storage; contents are qualified by the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= glip_in_data;
      mem_last[wr_ptr_q] <= wr_last;
    end
  end

  // FIFO pointers, occupancy and the held copy of the last departed flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (out_fire) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        hold_data_q <= mem_data[rd_ptr_q];
        hold_last_q <= mem_last[rd_ptr_q];
      end
      if (wr_en && !out_fire) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!wr_en && out_fire) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
  logic [15:0] pkt_count_q, drop_count_q;

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

  // Saturating packet and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (wr_en && wr_last && (pkt_count_q != 16'hFFFF)) pkt_count_q <= pkt_count_q + 16'd1;
      if (drop_evt && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mpsoc_glip_dii_deframer.sv
// Self-checking bench for mpsoc_glip_dii_deframer (MAX_PKT_LEN=12, FIFO_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_mpsoc_glip_dii_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] glip_in_data = '0;
  logic        glip_in_valid = 1'b0;
  logic        glip_in_ready;
  logic [15:0] dii_out_data;
  logic        dii_out_last;
  logic        dii_out_valid;
  logic        dii_out_ready = 1'b0;
  logic        busy;
`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
  logic [15:0] pkt_count, drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] got[$];

  mpsoc_glip_dii_deframer #(
    .MAX_PKT_LEN(12),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .glip_in_data (glip_in_data),
    .glip_in_valid(glip_in_valid),
    .glip_in_ready(glip_in_ready),
    .dii_out_data (dii_out_data),
    .dii_out_last (dii_out_last),
    .dii_out_valid(dii_out_valid),
    .dii_out_ready(dii_out_ready),
    .busy         (busy)
`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Record every flit that transfers (inputs are stable around the falling edge).
  always @(negedge clk) begin
    if (dii_out_valid && dii_out_ready) got.push_back({dii_out_last, dii_out_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one GLIP word and wait (bounded) until it is accepted.
  task automatic push(input logic [15:0] d, output int waits);
    waits = 0;
    glip_in_valid = 1'b1;
    glip_in_data  = d;
    @(negedge clk);
    while (!glip_in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) check("push_timeout", 32'(waits), 32'd0);
    step();
    glip_in_valid = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        e_ready;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int w;
    int wsum;

    // Header 3 + 3 words, then zero header, then header 1 + 0xABCD; dii_out_ready=1.
    tbl[0] = '{1'b1, 16'd3,      1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h1111,   1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'h2222,   1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h3333,   1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'd0,      1'b1, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 16'd1,      1'b1, 1'b1, 1'b0, 16'h3333, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 16'hABCD,   1'b1, 1'b1, 1'b0, 16'h3333, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000,   1'b1, 1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 16'h0000,   1'b1, 1'b1, 1'b0, 16'hABCD, 1'b1, 1'b0};

    // Reset values while reset is held.
    @(negedge clk);
    check("rst_ready", 32'(glip_in_ready), 32'd1);
    check("rst_valid", 32'(dii_out_valid), 32'd0);
    check("rst_data",  32'(dii_out_data),  32'd0);
    check("rst_last",  32'(dii_out_last),  32'd0);
    check("rst_busy",  32'(busy),          32'd0);
`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
    check("rst_pkt",  32'(pkt_count),  32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
`endif
    step();
    rst = 1'b0;

    // Table-driven cycle-by-cycle sequence.
    for (int i = 0; i < 9; i++) begin
      glip_in_valid = tbl[i].v;
      glip_in_data  = tbl[i].d;
      dii_out_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), 32'(glip_in_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_valid", i), 32'(dii_out_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_busy", i),  32'(busy),          32'(tbl[i].e_busy));
      if (tbl[i].e_valid || i >= 5) begin
        check($sformatf("tbl%0d_data", i), 32'(dii_out_data), 32'(tbl[i].e_data));
        check($sformatf("tbl%0d_last", i), 32'(dii_out_last), 32'(tbl[i].e_last));
      end
      step();
    end
    glip_in_valid = 1'b0;
    check("tbl_flits", 32'(got.size()), 32'd4);
`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
    check("tbl_pkt",  32'(pkt_count),  32'd2);
    check("tbl_drop", 32'(drop_count), 32'd1);
`endif

    // Oversize header 13 is dropped with ready held high, then header 2 passes.
    got.delete();
    wsum = 0;
    push(16'd13, w);
    wsum += w;
    for (int i = 0; i < 13; i++) begin
      push(16'hE000 + 16'(i), w);
      wsum += w;
    end
    check("drop_ready_waits", 32'(wsum), 32'd0);
    check("drop_no_flits", 32'(got.size()), 32'd0);
    push(16'd2, w);
    push(16'h0001, w);
    push(16'h0002, w);
    repeat (4) step();
    check("drop_flits", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("drop_f0", 32'(got[0]), 32'h0_0001);
      check("drop_f1", 32'(got[1]), 32'h1_0002);
    end
`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
    check("drop_cnt", 32'(drop_count), 32'd2);
`endif

    // Back-pressure: header 8 with dii_out_ready=0 fills the 4-entry FIFO.
    got.delete();
    dii_out_ready = 1'b0;
    wsum = 0;
    push(16'd8, w);
    for (int i = 0; i < 4; i++) begin
      push(16'h0100 + 16'(i), w);
      wsum += w;
    end
    check("bp_fill_waits", 32'(wsum), 32'd0);
    glip_in_valid = 1'b1;
    glip_in_data  = 16'h0104;
    @(negedge clk);
    check("bp_full_ready", 32'(glip_in_ready), 32'd0);
    check("bp_full_valid", 32'(dii_out_valid), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_still_blocked", 32'(glip_in_ready), 32'd0);
    step();
    dii_out_ready = 1'b1;
    for (int i = 4; i < 8; i++) push(16'h0100 + 16'(i), w);
    repeat (10) step();
    check("bp_flits", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("bp_f%0d", i), 32'(got[i]),
              {15'd0, (i == 7), 16'h0100 + 16'(i)});
      end
    end

    // Reset mid-packet: header 5, two words held in the FIFO, then reset.
    got.delete();
    dii_out_ready = 1'b0;
    push(16'd5, w);
    push(16'hC001, w);
    push(16'hC002, w);
    @(negedge clk);
    check("mid_valid_before", 32'(dii_out_valid), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(glip_in_ready), 32'd1);
    check("mid_rst_valid", 32'(dii_out_valid), 32'd0);
    check("mid_rst_data",  32'(dii_out_data),  32'd0);
    check("mid_rst_last",  32'(dii_out_last),  32'd0);
    check("mid_rst_busy",  32'(busy),          32'd0);
`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
    check("mid_rst_pkt",  32'(pkt_count),  32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
`endif
    step();
    rst = 1'b0;
    dii_out_ready = 1'b1;
    push(16'd1, w);
    push(16'h5A5A, w);
    repeat (4) step();
    check("mid_flits", 32'(got.size()), 32'd1);
    if (got.size() == 1) check("mid_f0", 32'(got[0]), 32'h1_5A5A);

`ifdef MPSOC_GLIP_DEFRAMER_STATS_EN
    // Packet counter saturation.
    force dut.pkt_count_q = 16'hFFFD;
    step();
    release dut.pkt_count_q;
    for (int i = 0; i < 3; i++) begin
      push(16'd1, w);
      push(16'h7700 + 16'(i), w);
    end
    repeat (6) step();
    check("sat_pkt", 32'(pkt_count), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mpsoc_glip_dii_deframer.md
# mpsoc_glip_dii_deframer

Ingress deframer between the host GLIP input channel (`c_glip_in`) and the debug interconnect of the MSP430 MPSoC. It consumes the 16-bit GLIP word stream, where each packet is a length header followed by that many payload words. It emits DII flits with `last` marking the final flit of each packet, and buffers them in a small FIFO so host back-pressure and NoC back-pressure are decoupled. Malformed packets (zero or oversize length) are discarded without reaching the debug network.

## Interface
Parameters:
- `MAX_PKT_LEN`, default 12: largest legal payload length in flits; matches `DEBUG_MAX_PKT_LEN`.
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  reset; asynchronous, active-high.
- `glip_in_data`  in  16  GLIP word (header or payload).
- `glip_in_valid`  in  1  GLIP word valid.
- `glip_in_ready`  out  1  block accepts the GLIP word this cycle.
- `dii_out_data`  out  16  DII flit data.
- `dii_out_last`  out  1  final flit of the packet.
- `dii_out_valid`  out  1  FIFO head valid.
- `dii_out_ready`  in  1  downstream accepts the head flit.
- `busy`  out  1  state is not IDLE, or the FIFO is not empty.
- `pkt_count`  out  16  packets fully forwarded; present only when the stats macro is defined.
- `drop_count`  out  16  packets discarded; present only when the stats macro is defined.

## Operation
- A GLIP word transfers when `glip_in_valid & glip_in_ready`. A flit transfers when `dii_out_valid & dii_out_ready`.
- State machine: IDLE, FWD, DROP.
  - IDLE: `glip_in_ready`=1. An accepted word is the header L, read as unsigned 16 bits.
  - From IDLE: L=0 stays in IDLE and counts as a drop. 1≤L≤MAX_PKT_LEN goes to FWD with `remaining`=L. L>MAX_PKT_LEN goes to DROP with `remaining`=L (17-bit down-counter).
  - FWD: `glip_in_ready` = FIFO not full. Each accepted word is written as {data, last=(remaining==1)} and decrements `remaining`. When `remaining` reaches 0, return to IDLE.
  - DROP: `glip_in_ready`=1. Each accepted word is discarded and decrements `remaining`. At 0, return to IDLE and count one drop.
- FIFO full: no write occurs, even if a read happens in the same cycle, because `glip_in_ready` depends only on the registered fullness.
- FIFO empty: `dii_out_valid`=0. `dii_out_data` and `dii_out_last` are don't-care but are held at their last value.
- Packets never interleave. Flits leave the FIFO in acceptance order.
- `rst` at any time, including mid-packet, does the following:
  - state goes to IDLE;
  - `remaining`=0;
  - the FIFO is emptied, and any partial packet is lost with no `last` emitted;
  - the counters are cleared.

## Timing
- Reset values:
  - `glip_in_ready`=1, `dii_out_valid`=0, `dii_out_data`=0, `dii_out_last`=0, `busy`=0;
  - `pkt_count`=0, `drop_count`=0.
- Latency: a payload word accepted at edge N is presented with `dii_out_valid`=1 after edge N (visible in cycle N+1). The header produces no flit.
- Throughput: one word per cycle in every state, provided the FIFO is not full.
- `dii_out_valid`, `dii_out_data` and `dii_out_last` come straight from FIFO registers; there is no combinational path from input to output.
- `glip_in_ready` has no combinational dependence on `glip_in_valid` or `dii_out_ready`.

## Configuration
- Macro `MPSOC_GLIP_DEFRAMER_STATS_EN`.
- Defined:
  - `pkt_count` and `drop_count` ports exist;
  - `pkt_count` increments on acceptance of a `last` word;
  - `drop_count` increments on a zero header or at DROP completion;
  - both counters saturate at 16'hFFFF.
- Undefined: the ports and counter registers are absent. All other behaviour is identical.

## Test plan
- Header 3, then words 0x1111, 0x2222, 0x3333 back-to-back, with `dii_out_ready`=1 → three flits in order, `last` only on 0x3333, first flit valid one cycle after its acceptance, `pkt_count`=1.
- Header 0, then header 1 with 0xABCD → no flit for the first packet; one flit 0xABCD with `last`=1; `drop_count`=1, `pkt_count`=1.
- Header 13 (with MAX_PKT_LEN=12) plus 13 words, then header 2 with 0x0001, 0x0002 → only 0x0001 and 0x0002 are emitted; `glip_in_ready` stays 1 throughout the drop; `drop_count`=1.
- Header 8 with `dii_out_ready`=0 → exactly 4 payload words are accepted, then `glip_in_ready`=0. After `dii_out_ready` is raised, all 8 flits arrive in order with `last` on the 8th.
- `rst` pulsed after 2 of 5 payload words → all outputs return to reset values with the FIFO empty. A following header 1 with 0x5A5A yields a single flit with `last`=1.
- With `MPSOC_GLIP_DEFRAMER_STATS_EN` defined, force `pkt_count` near saturation and send 3 packets → it holds at 16'hFFFF.
